// File: rtl/fsm_pkg.sv
// Shared state encoding for the rx-side sequencers.
// ST_SEND matches the receiver's "valid" code, so both sides can compare state_o directly.
package fsm_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'b00;
  localparam logic [ST_W-1:0] ST_WAIT = 2'b01;
  localparam logic [ST_W-1:0] ST_SEND = 2'b10;
  localparam logic [ST_W-1:0] ST_BAD  = 2'b11;

  typedef struct packed {
    logic [ST_W-1:0] state;
    logic            holding;
  } arb_status_t;

  function automatic logic isHolding(input logic [ST_W-1:0] s);
    return (s == ST_SEND) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/rx_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted request at or after ptr,
// wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_index,
  output logic             o_any
);

  logic [IDX_W-1:0] w_cand;

  // Scan N_REQ candidates starting at the pointer; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_index = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = IDX_W'((int'(i_ptr) + i) % N_REQ);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_index         = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_arbiter.sv
// Round-robin arbiter/sequencer feeding one word at a time to the receiver port.
// Holds the accepted word through receiver busy stalls and drops it after MAX_WAIT stalled cycles.
module rx_arbiter
  import fsm_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 5,
  parameter int MAX_WAIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    rx_valid_o,
  output logic [DATA_W-1:0]       rx_data_o,
  input  logic                    rx_ready_i,
  input  logic                    rx_busy_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic [1:0]              state_o,
  output logic                    timeout_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_WAIT);

  logic [ST_W-1:0]   r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_winIdx;
  logic [CNT_W-1:0]  r_waitCnt;
  logic              r_rxValid;
  logic [DATA_W-1:0] r_rxData;
  logic [N_REQ-1:0]  r_grant;
  logic              r_timeout;

  logic [N_REQ-1:0]  w_pickGrant;
  logic [IDX_W-1:0]  w_pickIdx;
  logic              w_pickAny;
  logic              w_accept;
  logic [DATA_W-1:0] w_reqWord [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_words
    assign w_reqWord[k] = req_data_i[k*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (req_valid_i),
    .i_ptr   (r_ptr),
    .o_grant (w_pickGrant),
    .o_index (w_pickIdx),
    .o_any   (w_pickAny)
  );

  function automatic logic [IDX_W-1:0] incPtr(input logic [IDX_W-1:0] p);
    if (int'(p) >= N_REQ - 1) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Accept pulse is combinational so the sender can retire its word on the same edge.
  assign w_accept    = !rst && (r_state == ST_IDLE) && w_pickAny && !rx_busy_i;
  assign req_ready_o = w_accept ? w_pickGrant : '0;

  assign rx_valid_o = r_rxValid;
  assign rx_data_o  = r_rxData;
  assign grant_o    = r_grant;
  assign state_o    = r_state;
  assign timeout_o  = r_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_winIdx  <= '0;
      r_waitCnt <= '0;
      r_rxValid <= 1'b0;
      r_rxData  <= '0;
      r_grant   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rxData  <= w_reqWord[w_pickIdx];
            r_rxValid <= 1'b1;
            r_grant   <= w_pickGrant;
            r_winIdx  <= w_pickIdx;
            r_state   <= ST_SEND;
          end
        end
        // Busy outranks ready: a busy receiver must not be handed the word.
        ST_SEND: begin
          if (rx_busy_i) begin
            r_state   <= ST_WAIT;
            r_waitCnt <= '0;
          end else if (rx_ready_i) begin
            r_rxValid <= 1'b0;
            r_grant   <= '0;
            r_ptr     <= incPtr(r_winIdx);
            r_state   <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!rx_busy_i) begin
            r_state <= ST_SEND;
          end else if (r_waitCnt == CNT_LAST) begin
            r_rxValid <= 1'b0;
            r_grant   <= '0;
            r_timeout <= 1'b1;
            r_ptr     <= incPtr(r_winIdx);
            r_state   <= ST_IDLE;
          end else if (r_waitCnt != CNT_SAT) begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        default: begin
          r_rxValid <= 1'b0;
          r_grant   <= '0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
